// File: rtl/slot_spin_controller.sv
// Three-reel slot game controller: starts the reels on a spin press, stops them one at a
// time on stop presses or timeout, scores the latched symbols and keeps a saturating balance.
module slot_spin_controller #(
    parameter int         CREDIT_W      = 8,
    parameter int         START_CREDITS = 10,
    parameter int         BET           = 1,
    parameter int         MIN_SPIN      = 16,
    parameter int         AUTO_STOP     = 255,
    parameter logic [3:0] JACKPOT_SYM   = 4'd7
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                spin_req,
    input  logic                stop_req,
    input  logic [3:0]          reel0_num,
    input  logic [3:0]          reel1_num,
    input  logic [3:0]          reel2_num,
    output logic [2:0]          reel_run,
    output logic [3:0]          held0,
    output logic [3:0]          held1,
    output logic [3:0]          held2,
    output logic [1:0]          win_code,
    output logic                result_valid,
    output logic [CREDIT_W-1:0] credits,
    output logic                busy
);

    localparam int CNT_MAX = (MIN_SPIN > AUTO_STOP) ? MIN_SPIN : AUTO_STOP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]    SPIN_LAST = CNT_W'(MIN_SPIN - 1);
    localparam logic [CNT_W-1:0]    AUTO_LAST = CNT_W'(AUTO_STOP - 1);
    localparam logic [CREDIT_W-1:0] BET_C     = CREDIT_W'(BET);
    localparam logic [CREDIT_W-1:0] START_C   = CREDIT_W'(START_CREDITS);
    localparam logic [CREDIT_W:0]   PAY_JACK  = (CREDIT_W + 1)'(20 * BET);
    localparam logic [CREDIT_W:0]   PAY_TRIP  = (CREDIT_W + 1)'(5 * BET);
    localparam logic [CREDIT_W:0]   PAY_PAIR  = (CREDIT_W + 1)'(2 * BET);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPIN,
        S_STOP0,
        S_STOP1,
        S_STOP2,
        S_EVAL
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                spin_prev_q;
    logic                stop_prev_q;
    logic [2:0]          reel_run_q;
    logic [3:0]          held_q [3];
    logic [1:0]          win_code_q;
    logic                result_valid_q;
    logic [CREDIT_W-1:0] credits_q;

    logic [3:0]          reel_num [3];
    logic                spin_edge;
    logic                stop_edge;
    logic [1:0]          stop_idx_d;
    state_t              stop_next_d;
    logic [1:0]          win_d;
    logic [CREDIT_W:0]   payout_d;
    logic [CREDIT_W:0]   sum_d;
    logic [CREDIT_W-1:0] credits_d;
    logic                triple_d;
    logic                pair_d;

    assign reel_num[0] = reel0_num;
    assign reel_num[1] = reel1_num;
    assign reel_num[2] = reel2_num;

    assign spin_edge = spin_req & ~spin_prev_q;
    assign stop_edge = stop_req & ~stop_prev_q;

    always_comb begin
        stop_idx_d  = 2'd2;
        stop_next_d = S_EVAL;
        case (state_q)
            S_STOP0: begin
                stop_idx_d  = 2'd0;
                stop_next_d = S_STOP1;
            end
            S_STOP1: begin
                stop_idx_d  = 2'd1;
                stop_next_d = S_STOP2;
            end
            default: begin
                stop_idx_d  = 2'd2;
                stop_next_d = S_EVAL;
            end
        endcase
    end

    // Scoring uses one extra bit so a large payout clamps at full scale instead of wrapping.
    always_comb begin
        triple_d = (held_q[0] == held_q[1]) && (held_q[1] == held_q[2]);
        pair_d   = (held_q[0] == held_q[1]) || (held_q[1] == held_q[2]) ||
                   (held_q[0] == held_q[2]);
        win_d    = 2'd0;
        payout_d = '0;
        if (triple_d && (held_q[0] == JACKPOT_SYM)) begin
            win_d    = 2'd3;
            payout_d = PAY_JACK;
        end else if (triple_d) begin
            win_d    = 2'd2;
            payout_d = PAY_TRIP;
        end else if (pair_d) begin
            win_d    = 2'd1;
            payout_d = PAY_PAIR;
        end
        sum_d     = {1'b0, credits_q} + payout_d;
        credits_d = sum_d[CREDIT_W] ? '1 : sum_d[CREDIT_W-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            spin_prev_q    <= 1'b0;
            stop_prev_q    <= 1'b0;
            reel_run_q     <= 3'b000;
            win_code_q     <= 2'd0;
            result_valid_q <= 1'b0;
            credits_q      <= START_C;
            for (int i = 0; i < 3; i++) held_q[i] <= 4'd0;
        end else begin
            spin_prev_q    <= spin_req;
            stop_prev_q    <= stop_req;
            result_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (spin_edge && (credits_q >= BET_C)) begin
                        credits_q  <= credits_q - BET_C;
                        reel_run_q <= 3'b111;
                        win_code_q <= 2'd0;
                        cnt_q      <= '0;
                        state_q    <= S_SPIN;
                        for (int i = 0; i < 3; i++) held_q[i] <= 4'd0;
                    end
                end
                S_SPIN: begin
                    if (cnt_q == SPIN_LAST) begin
                        cnt_q   <= '0;
                        state_q <= S_STOP0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_STOP0, S_STOP1, S_STOP2: begin
                    // Latch the reel while it is still running so the player sees what was on screen.
                    if (stop_edge || (cnt_q == AUTO_LAST)) begin
                        held_q[stop_idx_d]     <= reel_num[stop_idx_d];
                        reel_run_q[stop_idx_d] <= 1'b0;
                        cnt_q                  <= '0;
                        state_q                <= stop_next_d;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_EVAL: begin
                    win_code_q     <= win_d;
                    credits_q      <= credits_d;
                    result_valid_q <= 1'b1;
                    state_q        <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign reel_run     = reel_run_q;
    assign held0        = held_q[0];
    assign held1        = held_q[1];
    assign held2        = held_q[2];
    assign win_code     = win_code_q;
    assign result_valid = result_valid_q;
    assign credits      = credits_q;
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_slot_spin_controller.sv
// Scoreboard bench for slot_spin_controller: stimulus pushes expected results, a monitor
// pops and compares them whenever result_valid pulses.
module tb_slot_spin_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       spin_req = 1'b0;
    logic       stop_req = 1'b0;
    logic [3:0] reel0_num = 4'd0;
    logic [3:0] reel1_num = 4'd0;
    logic [3:0] reel2_num = 4'd0;
    logic [2:0] reel_run;
    logic [3:0] held0, held1, held2;
    logic [1:0] win_code;
    logic       result_valid;
    logic [7:0] credits;
    logic       busy;

    slot_spin_controller dut (
        .clk          (clk),
        .reset        (reset),
        .spin_req     (spin_req),
        .stop_req     (stop_req),
        .reel0_num    (reel0_num),
        .reel1_num    (reel1_num),
        .reel2_num    (reel2_num),
        .reel_run     (reel_run),
        .held0        (held0),
        .held1        (held1),
        .held2        (held2),
        .win_code     (win_code),
        .result_valid (result_valid),
        .credits      (credits),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int win;
        int cred;
        int h0;
        int h1;
        int h2;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;
    int   exp_cred;
    logic rv_prev = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int pay(input int win);
        case (win)
            3: return 20;
            2: return 5;
            1: return 2;
            default: return 0;
        endcase
    endfunction

    // Expected balance after one bet and the payout for the given hand-computed win code.
    task automatic expect_result(input int win, input int h0, input int h1, input int h2);
        exp_t e;
        exp_cred = exp_cred - 1 + pay(win);
        if (exp_cred > 255) exp_cred = 255;
        e.win = win; e.cred = exp_cred; e.h0 = h0; e.h1 = h1; e.h2 = h2;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (result_valid) begin
            check("result_valid_single_pulse", int'(rv_prev), 0);
            if (sb_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("win_code", int'(win_code), e.win);
                check("credits_after_eval", int'(credits), e.cred);
                check("held_at_result", {int'(held0), int'(held1), int'(held2)} == {e.h0, e.h1, e.h2} ? 1 : 0, 1);
                $display("[TB] result win=%0d credits=%0d held=%0d,%0d,%0d", win_code, credits, held0, held1, held2);
            end
        end
        rv_prev <= result_valid;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        #2 reset = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
        exp_cred = 10;
    endtask

    task automatic start_spin();
        spin_req = 1'b1;
        tick(1);
        spin_req = 1'b0;
        tick(1);
    endtask

    // Present v on reel i, press stop for one cycle, then scramble the reels so the held value must be the latched one.
    task automatic stop_reel(input int i, input logic [3:0] v);
        if (i == 0) reel0_num = v; else if (i == 1) reel1_num = v; else reel2_num = v;
        stop_req = 1'b1;
        tick(1);
        stop_req = 1'b0;
        reel0_num = 4'hF; reel1_num = 4'hE; reel2_num = 4'hD;
        tick(1);
        check($sformatf("reel_run_after_stop%0d", i), int'(reel_run), int'(3'b111 << (i + 1)) & 7);
        if (i == 0) check("held0_latch", int'(held0), int'(v));
        else if (i == 1) check("held1_latch", int'(held1), int'(v));
        else check("held2_latch", int'(held2), int'(v));
    endtask

    task automatic full_spin(input logic [3:0] v0, input logic [3:0] v1, input logic [3:0] v2, input int win);
        expect_result(win, v0, v1, v2);
        start_spin();
        tick(20);
        stop_reel(0, v0);
        stop_reel(1, v1);
        stop_reel(2, v2);
        tick(2);
        $display("[TB] spin %0d,%0d,%0d expect win=%0d credits=%0d", v0, v1, v2, win, exp_cred);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc, t_spin, t0, t1, t2;
        logic [2:0] prev_run;

        exp_cred = 10;
        tick(3);
        reset = 1'b1;
        tick(1);

        // Reset state
        check("reset_credits", int'(credits), 10);
        check("reset_reel_run", int'(reel_run), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_win_code", int'(win_code), 0);
        check("reset_held", int'({held0, held1, held2}), 0);
        $display("[TB] reset state checked");

        // Spin with an early stop that must be discarded
        expect_result(0, 5, 9, 4);
        spin_req = 1'b1;
        tick(1);
        check("spin_credits_debit", int'(credits), 9);
        check("spin_reel_run", int'(reel_run), 7);
        check("spin_busy", int'(busy), 1);
        spin_req = 1'b0;
        tick(4);
        stop_req = 1'b1;
        tick(1);
        stop_req = 1'b0;
        tick(1);
        check("early_stop_ignored", int'(reel_run), 7);
        tick(20);
        check("early_stop_not_queued", int'(reel_run), 7);
        stop_reel(0, 4'd5);
        stop_reel(1, 4'd9);
        stop_reel(2, 4'd4);
        tick(2);
        $display("[TB] spin 5,9,4 expect win=0 credits=%0d", exp_cred);

        // Jackpot from a fresh balance
        do_reset();
        full_spin(4'd7, 4'd7, 4'd7, 3);
        check("jackpot_credits", int'(credits), 29);

        // Auto-stop timing with a pair
        reel0_num = 4'd3; reel1_num = 4'd3; reel2_num = 4'd5;
        expect_result(1, 3, 3, 5);
        spin_req = 1'b1;
        cyc = 0; t_spin = -1; t0 = -1; t1 = -1; t2 = -1;
        prev_run = 3'b000;
        while (cyc < 1000 && t2 < 0) begin
            @(negedge clk);
            cyc++;
            if (reel_run == 3'b111 && t_spin < 0) t_spin = cyc;
            if (prev_run[0] && !reel_run[0]) t0 = cyc;
            if (prev_run[1] && !reel_run[1]) t1 = cyc;
            if (prev_run[2] && !reel_run[2]) t2 = cyc;
            prev_run = reel_run;
        end
        spin_req = 1'b0;
        @(posedge clk);
        #1;
        check("auto_stop0_delay", t0 - t_spin, 16 + 255);
        check("auto_stop1_delay", t1 - t0, 255);
        check("auto_stop2_delay", t2 - t1, 255);
        check("auto_held", int'({held0, held1, held2}), int'({4'd3, 4'd3, 4'd5}));
        tick(3);
        check("auto_pair_credits", int'(credits), 30);
        $display("[TB] auto-stop intervals %0d %0d %0d", t0 - t_spin, t1 - t0, t2 - t1);

        // Held stop button stops only reel 0; simultaneous spin+stop in STOP2 stops reel 2 only
        expect_result(1, 6, 2, 6);
        start_spin();
        tick(20);
        reel0_num = 4'd6;
        stop_req = 1'b1;
        tick(10);
        check("held_stop_only_reel0", int'(reel_run), 3'b110);
        check("held_stop_held0", int'(held0), 6);
        stop_req = 1'b0;
        tick(1);
        stop_reel(1, 4'd2);
        reel2_num = 4'd6;
        spin_req = 1'b1;
        stop_req = 1'b1;
        tick(1);
        spin_req = 1'b0;
        stop_req = 1'b0;
        tick(1);
        check("simul_reel_run", int'(reel_run), 0);
        check("simul_held2", int'(held2), 6);
        tick(4);
        check("simul_spin_ignored_busy", int'(busy), 0);
        check("simul_credits", int'(credits), 31);
        $display("[TB] simultaneous edges in STOP2 checked");

        // Async reset in the middle of STOP1
        start_spin();
        tick(20);
        stop_reel(0, 4'd1);
        tick(3);
        #2 reset = 1'b0;
        #1;
        check("async_reset_reel_run", int'(reel_run), 0);
        check("async_reset_credits", int'(credits), 10);
        check("async_reset_busy", int'(busy), 0);
        @(posedge clk);
        #1 reset = 1'b1;
        tick(1);
        exp_cred = 10;
        $display("[TB] async reset mid-STOP1 checked");

        // Exhaust the balance with losing spins
        for (int k = 0; k < 10; k++) full_spin(4'd1, 4'd2, 4'd3, 0);
        check("exhausted_credits", int'(credits), 0);
        start_spin();
        tick(4);
        check("no_credit_busy", int'(busy), 0);
        check("no_credit_reel_run", int'(reel_run), 0);
        check("no_credit_credits", int'(credits), 0);
        $display("[TB] spin at zero credits ignored");

        // Repeated jackpots saturate the balance at 255
        do_reset();
        for (int k = 0; k < 14; k++) full_spin(4'd7, 4'd7, 4'd7, 3);
        check("saturated_credits", int'(credits), 255);

        tick(5);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
